// File: rtl/imem_block_memory_pkg.sv
// Shared I-side memory constants, FSM state encoding and the parity helper.
`default_nettype none

package imem_block_memory_pkg;

  localparam int IWORD_SIZE_BITS      = 32;
  localparam int IBLOCK_SIZE_BITS     = 128;
  localparam int IBLOCK_OFFSET_SIZE   = 4;
  localparam int IMEM_BLOCK_ADDR_SIZE = 32 - IBLOCK_OFFSET_SIZE;
  localparam int IWORDS_PER_BLOCK     = IBLOCK_SIZE_BITS / IWORD_SIZE_BITS;
  localparam int IWORD_IDX_SIZE       = $clog2(IWORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BEAT = 2'd2,
    S_DONE = 2'd3
  } imem_state_e;

  // Even parity: stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [IWORD_SIZE_BITS-1:0] w);
    return ^w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_block_memory_counter.sv
// Loadable down-counter with terminal-count output, shared by the latency and beat phases.
`default_nettype none

module imem_block_memory_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign tc_o    = en_i && (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/imem_block_memory.sv
// Instruction main-memory model: fixed-latency block read assembled word by word.
// Optional per-word even parity is enabled with the IMEM_PARITY_EN macro.
`default_nettype none

module imem_block_memory
  import imem_block_memory_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int FIRST_LAT       = 4,
  parameter int BEAT_LAT        = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               memRen,
  input  logic [IMEM_BLOCK_ADDR_SIZE-1:0]    BlockAddr,
  output logic                               memReadReady,
  output logic [IBLOCK_SIZE_BITS-1:0]        memIout,
  output logic                               memBusy,
  input  logic                               loadWen,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] loadAddr,
  input  logic [IWORD_SIZE_BITS-1:0]         loadData,
  input  logic                               loadBadParity,
  output logic                               memErr
);

  localparam int AW     = $clog2(MEM_DEPTH_WORDS);
  localparam int KW     = IWORD_IDX_SIZE;
  localparam int BW     = AW - KW;
  localparam int MAXLAT = (FIRST_LAT > BEAT_LAT) ? FIRST_LAT : BEAT_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [IWORD_SIZE_BITS-1:0] mem [MEM_DEPTH_WORDS];

  imem_state_e                 state_q;
  logic [BW-1:0]               addr_q;
  logic [KW-1:0]               beat_q;
  logic [IBLOCK_SIZE_BITS-1:0] blk_q;
  logic [IBLOCK_SIZE_BITS-1:0] blk_d;
  logic [IBLOCK_SIZE_BITS-1:0] iout_q;
  logic                        ready_q;
  logic                        busy_q;
  logic                        err_q;
  logic                        erracc_q;
  logic                        erracc_d;

  logic [AW-1:0]               rd_addr;
  logic [IWORD_SIZE_BITS-1:0]  rd_word;
  logic                        beat_err;
  logic                        last_beat;

  logic                        cnt_load;
  logic [CW-1:0]               cnt_load_val;
  logic                        cnt_en;
  logic                        cnt_tc;
  logic [CW-1:0]               unused_cnt;
  logic [IMEM_BLOCK_ADDR_SIZE-BW-1:0] unused_addr_hi;

  // Array is deliberately unreset: reset must not disturb a preloaded program.
  always_ff @(posedge clock) begin
    if (loadWen) begin
      mem[loadAddr] <= loadData;
    end
  end

  assign rd_addr   = {addr_q, beat_q};
  assign rd_word   = mem[rd_addr];
  assign last_beat = (beat_q == KW'(IWORDS_PER_BLOCK - 1));

`ifdef IMEM_PARITY_EN
  logic par_mem [MEM_DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (loadWen) begin
      par_mem[loadAddr] <= even_parity(loadData) ^ loadBadParity;
    end
  end

  assign beat_err = (even_parity(rd_word) != par_mem[rd_addr]);
`else
  logic unused_bad_par;
  assign unused_bad_par = loadBadParity;
  assign beat_err       = 1'b0;
`endif

  always_comb begin
    blk_d = blk_q;
    blk_d[beat_q*IWORD_SIZE_BITS +: IWORD_SIZE_BITS] = rd_word;
    erracc_d = erracc_q | beat_err;
  end

  assign cnt_en       = (state_q == S_WAIT) || (state_q == S_BEAT);
  assign cnt_load     = ((state_q == S_IDLE) && memRen) ||
                        ((state_q == S_WAIT) && cnt_tc) ||
                        ((state_q == S_BEAT) && cnt_tc && !last_beat);
  assign cnt_load_val = (state_q == S_IDLE) ? CW'(FIRST_LAT) : CW'(BEAT_LAT);

  imem_block_memory_counter #(
    .WIDTH (CW)
  ) u_counter (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .count_o    (unused_cnt),
    .tc_o       (cnt_tc)
  );

  // The last beat writes memIout directly, so the pulse lands on the edge of the final read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      blk_q    <= '0;
      iout_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      erracc_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (memRen) begin
            addr_q   <= BlockAddr[BW-1:0];
            beat_q   <= '0;
            erracc_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_tc) begin
            beat_q  <= '0;
            state_q <= S_BEAT;
          end
        end
        S_BEAT: begin
          if (cnt_tc) begin
            blk_q    <= blk_d;
            beat_q   <= beat_q + 1'b1;
            erracc_q <= erracc_d;
            if (last_beat) begin
              iout_q  <= blk_d;
              ready_q <= 1'b1;
              err_q   <= erracc_d;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign unused_addr_hi = BlockAddr[IMEM_BLOCK_ADDR_SIZE-1:BW];

  assign memReadReady = ready_q;
  assign memIout      = iout_q;
  assign memBusy      = busy_q;
  assign memErr       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_block_memory.sv
// Randomised self-checking bench for imem_block_memory against an array-level reference model.
`default_nettype none

module tb_imem_block_memory;
  import imem_block_memory_pkg::*;

  localparam int DEPTH = 1024;
  localparam int FL    = 4;
  localparam int BL    = 1;
  localparam int WPB   = IWORDS_PER_BLOCK;
  localparam int LAT   = FL + WPB * BL;
  localparam int NBLK  = DEPTH / WPB;

  logic                            clock = 1'b0;
  logic                            reset = 1'b0;
  logic                            memRen = 1'b0;
  logic [IMEM_BLOCK_ADDR_SIZE-1:0] BlockAddr = '0;
  logic                            memReadReady;
  logic [IBLOCK_SIZE_BITS-1:0]     memIout;
  logic                            memBusy;
  logic                            loadWen = 1'b0;
  logic [$clog2(DEPTH)-1:0]        loadAddr = '0;
  logic [IWORD_SIZE_BITS-1:0]      loadData = '0;
  logic                            loadBadParity = 1'b0;
  logic                            memErr;

  imem_block_memory #(
    .MEM_DEPTH_WORDS (DEPTH),
    .FIRST_LAT       (FL),
    .BEAT_LAT        (BL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .memRen        (memRen),
    .BlockAddr     (BlockAddr),
    .memReadReady  (memReadReady),
    .memIout       (memIout),
    .memBusy       (memBusy),
    .loadWen       (loadWen),
    .loadAddr      (loadAddr),
    .loadData      (loadData),
    .loadBadParity (loadBadParity),
    .memErr        (memErr)
  );

  always #5 clock = ~clock;

  logic [31:0] mem_m [DEPTH];
  bit          bad_m [DEPTH];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic load_word(input int a, input logic [31:0] d, input bit b);
    loadWen = 1'b1; loadAddr = 10'(a); loadData = d; loadBadParity = b;
    @(negedge clock);
    loadWen = 1'b0; loadBadParity = 1'b0;
    mem_m[a] = d;
    bad_m[a] = b;
  endtask

  // One block read with an optional backdoor write landing on edge E0+mw_cyc to word mw_k.
  task automatic do_read(input logic [27:0] ba, input bit mw_en, input int mw_cyc,
                         input int mw_k, input logic [31:0] mw_d, input bit mw_b,
                         input string tag);
    logic [127:0] exp;
    bit   exp_err;
    int   base, got_at, pulses;
    base    = int'(ba % 28'(NBLK)) * WPB;
    exp     = '0;
    exp_err = 1'b0;
    for (int k = 0; k < WPB; k++) begin
      if (mw_en && mw_k == k && mw_cyc < FL + (k + 1) * BL) begin
        exp[k*32 +: 32] = mw_d;
        exp_err |= mw_b;
      end else begin
        exp[k*32 +: 32] = mem_m[base + k];
        exp_err |= bad_m[base + k];
      end
    end
`ifndef IMEM_PARITY_EN
    exp_err = 1'b0;
`endif
    memRen = 1'b1; BlockAddr = ba;
    @(posedge clock);
    got_at = -1;
    pulses = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clock);
      if (i == 1) begin
        memRen = 1'b0;
        check_val({tag, "_busy_rise"}, memBusy, 1'b1);
      end
      if (i == LAT + 2) check_val({tag, "_busy_fall"}, memBusy, 1'b0);
      if (memReadReady) begin
        pulses++;
        if (got_at < 0) begin
          got_at = i;
          check_val({tag, "_data"}, memIout, exp);
          check_val({tag, "_err"}, memErr, exp_err);
        end
      end
      if (got_at > 0 && i == got_at + 3) check_val({tag, "_hold"}, memIout, exp);
      loadWen = 1'b0; loadBadParity = 1'b0;
      if (mw_en && i == mw_cyc) begin
        loadWen = 1'b1; loadAddr = 10'(base + mw_k); loadData = mw_d; loadBadParity = mw_b;
      end
    end
    loadWen = 1'b0; loadBadParity = 1'b0;
    check_val({tag, "_latency"}, got_at, LAT + 1);
    check_val({tag, "_pulses"}, pulses, 1);
    if (mw_en) begin
      mem_m[base + mw_k] = mw_d;
      bad_m[base + mw_k] = mw_b;
    end
  endtask

  initial begin
    int pulses;
    logic [127:0] held_exp;
    logic [127:0] basic_exp;

    repeat (2) @(negedge clock);
    check_val("rst_ready", memReadReady, 1'b0);
    check_val("rst_busy", memBusy, 1'b0);
    check_val("rst_err", memErr, 1'b0);
    check_val("rst_iout", memIout, '0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < DEPTH; i++)
      load_word(i, (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom, 1'b0);

    // Basic read of block 1 against hand-written constants.
    do_read(28'd1, 1'b0, 0, 0, '0, 1'b0, "basic");
    basic_exp = {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004};
    check_val("basic_const", memIout, basic_exp);

    // Request held high: completions every LAT+2 cycles, then drop after third acceptance.
    held_exp = {mem_m[15], mem_m[14], mem_m[13], mem_m[12]};
    memRen = 1'b1; BlockAddr = 28'd3;
    @(posedge clock);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      check_val("held_ready", memReadReady,
                (i == LAT + 1) || (i == 2 * LAT + 3) || (i == 3 * LAT + 5));
      if (memReadReady) check_val("held_data", memIout, held_exp);
      if (i == 2 * LAT + 5) memRen = 1'b0;
    end

    // Wrap: high block-address bits beyond the array are dropped.
    do_read(28'(NBLK + 2), 1'b0, 0, 0, '0, 1'b0, "wrap");
    check_val("wrap_w0", memIout[31:0], mem_m[8]);

    // Reset during BEAT.
    memRen = 1'b1; BlockAddr = 28'd1;
    @(posedge clock);
    @(negedge clock); memRen = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("mrst_ready", memReadReady, 1'b0);
    check_val("mrst_busy", memBusy, 1'b0);
    check_val("mrst_err", memErr, 1'b0);
    check_val("mrst_iout", memIout, '0);
    @(negedge clock); reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (memReadReady) pulses++;
    end
    check_val("mrst_no_pulse", pulses, 0);
    do_read(28'd1, 1'b0, 0, 0, '0, 1'b0, "post_rst");
    check_val("post_rst_const", memIout, basic_exp);

    // Backdoor write to word 2 while its beat is pending; word 0 already beaten.
    do_read(28'd0, 1'b1, 6, 2, 32'hDEAD_BEEF, 1'b0, "ldrd");
    check_val("ldrd_w2", memIout[95:64], 32'hDEAD_BEEF);
    check_val("ldrd_w0", memIout[31:0], 32'h1000_0000);

    // Parity: bad word inside block 1, clean block 0 afterwards.
    load_word(5, mem_m[5], 1'b1);
    do_read(28'd1, 1'b0, 0, 0, '0, 1'b0, "par_bad");
    do_read(28'd0, 1'b0, 0, 0, '0, 1'b0, "par_good");
    load_word(5, mem_m[5], 1'b0);

    // Randomised reads with occasional loads and mid-read writes.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1)
        load_word($urandom_range(0, DEPTH - 1), $urandom, ($urandom_range(0, 7) == 0));
      do_read(28'($urandom), ($urandom_range(0, 1) == 1), $urandom_range(1, LAT),
              $urandom_range(0, WPB - 1), $urandom, ($urandom_range(0, 3) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
